paj7620_slave_model: RTL

Synthesizable I2C responder that emulates the PAJ7620 gesture sensor, the target end of the bus driven by our gesture-sensor I2C master.
- Decodes START/STOP, matches the 7-bit device address, and ACKs writes.
- Serves a small register map: part ID, bank select, and a clear-on-read gesture flag register.
- Used on-board as a loopback target and in simulation, so the master and the gesture/beep/seg logic can run without the physical sensor.

---
 rtl/paj7620_slave_pkg.sv | 37 +++
 rtl/paj7620_slave_model_if.sv | 11 +
 rtl/paj7620_slave_model_i2c_bus_sync.sv | 36 +++
 rtl/paj7620_slave_model.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/paj7620_slave_pkg.sv
// Shared constants for the PAJ7620 I2C target model: FSM encodings, register
// addresses and the read-side register map.
package paj7620_slave_pkg;

  typedef logic [3:0] state_t;

  localparam state_t ST_IDLE      = 4'd0;
  localparam state_t ST_ADDR      = 4'd1;
  localparam state_t ST_ADDR_ACK  = 4'd2;
  localparam state_t ST_REG       = 4'd3;
  localparam state_t ST_REG_ACK   = 4'd4;
  localparam state_t ST_WDATA     = 4'd5;
  localparam state_t ST_WDATA_ACK = 4'd6;
  localparam state_t ST_RDATA     = 4'd7;
  localparam state_t ST_RD_MACK   = 4'd8;
  localparam state_t ST_WAIT_STOP = 4'd9;

  localparam logic [7:0] REG_PID_L = 8'h00;
  localparam logic [7:0] REG_PID_H = 8'h01;
  localparam logic [7:0] REG_GES   = 8'h43;
  localparam logic [7:0] REG_BANK  = 8'hEF;

  // The gesture register is only visible in bank 0; unmapped addresses read 0.
  function automatic logic [7:0] read_map(input logic [7:0]  addr,
                                          input logic        bank,
                                          input logic [7:0]  flags,
                                          input logic [15:0] part_id);
    case (addr)
      REG_PID_L: read_map = part_id[7:0];
      REG_PID_H: read_map = part_id[15:8];
      REG_GES:   read_map = bank ? 8'h00 : flags;
      REG_BANK:  read_map = {7'b0, bank};
      default:   read_map = 8'h00;
    endcase
  endfunction

endpackage

// File: rtl/paj7620_slave_model_if.sv
// I2C bus seen from the target: raw SCL/SDA levels in, open-drain SDA enable out.
interface paj7620_slave_model_if;
  // The physical SDA line is a wired-AND: the target pulls it low with sda_oe=1,
  // and sda_oe only changes while SCL is low, so data is stable while SCL is high.
  logic scl_in;
  logic sda_in;
  logic sda_oe;

  modport master (output scl_in, output sda_in, input sda_oe);
  modport slave  (input scl_in, input sda_in, output sda_oe);
endinterface

// File: rtl/paj7620_slave_model_i2c_bus_sync.sv
// Brings asynchronous SCL/SDA into the clk domain and derives single-cycle
// SCL edge, START and STOP pulses.
module i2c_bus_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic scl_in,
  input  logic sda_in,
  output logic sda,
  output logic scl_rise,
  output logic scl_fall,
  output logic start,
  output logic stop
);

  // [0],[1] are the synchronizer pair, [2] is the delayed copy. Reset to the
  // idle-high bus level so leaving reset never fakes an edge.
  logic [2:0] scl_sh;
  logic [2:0] sda_sh;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scl_sh <= 3'b111;
      sda_sh <= 3'b111;
    end else begin
      scl_sh <= {scl_sh[1:0], scl_in};
      sda_sh <= {sda_sh[1:0], sda_in};
    end
  end

  assign sda      = sda_sh[1];
  assign scl_rise = scl_sh[1] & ~scl_sh[2];
  assign scl_fall = ~scl_sh[1] & scl_sh[2];
  assign start    = scl_sh[1] & sda_sh[2] & ~sda_sh[1];
  assign stop     = scl_sh[1] & ~sda_sh[2] & sda_sh[1];

endmodule

// File: rtl/paj7620_slave_model.sv
// PAJ7620 gesture-sensor I2C target: address match, register pointer, bank
// select and a clear-on-read gesture flag register.
module paj7620_slave_model
  import paj7620_slave_pkg::*;
#(
  parameter logic [6:0]  DEV_ADDR = 7'h73,
  parameter logic [15:0] PART_ID  = 16'h7620
) (
  input  logic                        clk,
  input  logic                        rst_n,
  paj7620_slave_model_if.slave        bus,
  input  logic [7:0]                  gesture_in,
  input  logic                        gesture_valid,
  output logic                        bank_sel,
  output logic                        busy,
  output logic                        rd_clr,
  output logic [3:0]                  state_dbg
);

  logic       sda_s;
  logic       scl_rise;
  logic       scl_fall;
  logic       start_det;
  logic       stop_det;

  state_t     state;
  logic [3:0] bit_cnt;
  logic [7:0] rx_sh;
  logic [7:0] tx_sh;
  logic [7:0] ptr;
  logic [7:0] flags;
  logic       sda_oe_q;

  logic       load_now;
  logic [7:0] load_addr;
  logic [7:0] load_byte;
  logic       ges_clr;

  i2c_bus_sync u_sync (
    .clk      (clk),
    .rst_n    (rst_n),
    .scl_in   (bus.scl_in),
    .sda_in   (bus.sda_in),
    .sda      (sda_s),
    .scl_rise (scl_rise),
    .scl_fall (scl_fall),
    .start    (start_det),
    .stop     (stop_det)
  );

  assign bus.sda_oe = sda_oe_q;
  assign state_dbg  = state;

  // A read byte is fetched on the SCL fall that starts its first data bit:
  // either right after the address ACK, or after a master ACK (next address).
  always_comb begin
    load_now  = 1'b0;
    load_addr = ptr;
    if (!start_det && !stop_det && scl_fall) begin
      if (state == ST_ADDR_ACK && rx_sh[0]) begin
        load_now = 1'b1;
      end
      if (state == ST_RD_MACK && bit_cnt == 4'd9) begin
        load_now  = 1'b1;
        load_addr = ptr + 8'd1;
      end
    end
  end

  assign load_byte = read_map(load_addr, bank_sel, flags, PART_ID);
  assign ges_clr   = load_now && (load_addr == REG_GES) && !bank_sel;

  // Gesture events arriving in the clear cycle are kept, not lost.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flags  <= 8'h00;
      rd_clr <= 1'b0;
    end else begin
      rd_clr <= ges_clr;
      if (ges_clr) begin
        flags <= gesture_valid ? gesture_in : 8'h00;
      end else if (gesture_valid) begin
        flags <= flags | gesture_in;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      bit_cnt  <= 4'd0;
      rx_sh    <= 8'h00;
      tx_sh    <= 8'h00;
      ptr      <= 8'h00;
      sda_oe_q <= 1'b0;
      busy     <= 1'b0;
      bank_sel <= 1'b0;
    end else if (start_det) begin
      state    <= ST_ADDR;
      bit_cnt  <= 4'd0;
      busy     <= 1'b1;
      sda_oe_q <= 1'b0;
    end else if (stop_det) begin
      state    <= ST_IDLE;
      busy     <= 1'b0;
      sda_oe_q <= 1'b0;
    end else begin
      case (state)
        ST_ADDR: begin
          if (scl_rise) begin
            rx_sh   <= {rx_sh[6:0], sda_s};
            bit_cnt <= bit_cnt + 4'd1;
          end else if (scl_fall && bit_cnt == 4'd8) begin
            bit_cnt <= 4'd0;
            if (rx_sh[7:1] == DEV_ADDR) begin
              state    <= ST_ADDR_ACK;
              sda_oe_q <= 1'b1;
            end else begin
              state <= ST_WAIT_STOP;
            end
          end
        end
        ST_ADDR_ACK: begin
          if (scl_fall) begin
            bit_cnt <= 4'd0;
            if (rx_sh[0]) begin
              state    <= ST_RDATA;
              tx_sh    <= load_byte;
              sda_oe_q <= ~load_byte[7];
            end else begin
              state    <= ST_REG;
              sda_oe_q <= 1'b0;
            end
          end
        end
        ST_REG: begin
          if (scl_rise) begin
            rx_sh   <= {rx_sh[6:0], sda_s};
            bit_cnt <= bit_cnt + 4'd1;
          end else if (scl_fall && bit_cnt == 4'd8) begin
            bit_cnt  <= 4'd0;
            ptr      <= rx_sh;
            state    <= ST_REG_ACK;
            sda_oe_q <= 1'b1;
          end
        end
        ST_REG_ACK, ST_WDATA_ACK: begin
          if (scl_fall) begin
            state    <= ST_WDATA;
            sda_oe_q <= 1'b0;
          end
        end
        ST_WDATA: begin
          if (scl_rise) begin
            rx_sh   <= {rx_sh[6:0], sda_s};
            bit_cnt <= bit_cnt + 4'd1;
          end else if (scl_fall && bit_cnt == 4'd8) begin
            bit_cnt <= 4'd0;
            if (ptr == REG_BANK) begin
              bank_sel <= rx_sh[0];
            end
            ptr      <= ptr + 8'd1;
            state    <= ST_WDATA_ACK;
            sda_oe_q <= 1'b1;
          end
        end
        ST_RDATA: begin
          if (scl_rise) begin
            bit_cnt <= bit_cnt + 4'd1;
          end else if (scl_fall) begin
            if (bit_cnt == 4'd8) begin
              state    <= ST_RD_MACK;
              sda_oe_q <= 1'b0;
            end else begin
              tx_sh    <= {tx_sh[6:0], 1'b0};
              sda_oe_q <= ~tx_sh[6];
            end
          end
        end
        ST_RD_MACK: begin
          // bit_cnt==9 marks "master ACK seen, waiting for the fall".
          if (scl_rise) begin
            if (sda_s) begin
              state <= ST_WAIT_STOP;
            end else begin
              bit_cnt <= 4'd9;
            end
          end else if (scl_fall && bit_cnt == 4'd9) begin
            bit_cnt  <= 4'd0;
            ptr      <= ptr + 8'd1;
            tx_sh    <= load_byte;
            sda_oe_q <= ~load_byte[7];
            state    <= ST_RDATA;
          end
        end
        ST_IDLE, ST_WAIT_STOP: begin
          sda_oe_q <= 1'b0;
        end
        default: begin
          state    <= ST_IDLE;
          sda_oe_q <= 1'b0;
        end
      endcase
    end
  end

endmodule
